// File: rtl/fmap_accumulator.sv
// fmap_accumulator
//   Read-modify-write requester for the convolution-side feature-map ports.
//   Each accepted event (x, y, per-channel delta) reads the stored neuron
//   vector, adds the sign-extended deltas to every channel and writes the
//   result back. The pipeline takes one event per cycle. A result that is
//   still in S3 or S4 is forwarded into S2, so back-to-back events to the
//   same coordinate accumulate correctly.
//
//   Stages: S1 accept/read issue, S2 operand select + add, S3 write issue,
//   S4 forwarding copy of the last write.
//
//   Configuration macro: FMAP_ACC_SAT_EN
//     defined   -> each channel sum saturates to the signed neuron range
//     undefined -> each channel sum wraps modulo 2^BITS_PER_NEURON
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     en              accept enable (high only in convolution mode)
//     ev_valid/ready  event handshake; ev_ready = en
//     ev_x, ev_y      event coordinate
//     ev_delta        packed signed deltas, channel i at [i*BPW +: BPW]
//     read_req        read request, combinational from the accepted event
//     coord_get       read coordinate {x,y}
//     rd_data         read data, valid the cycle after read_req
//     write_req       write request (S3)
//     coord_wtr       write coordinate {x,y}
//     wr_data         write data, same channel layout as rd_data
//     busy            any of S2/S3/S4 valid

// One channel adder. The delta is sign-extended to the neuron width.
module fmap_acc_lane #(
  parameter int N = 12,
  parameter int W = 6
) (
  input  logic [N-1:0] opnd_i,
  input  logic [W-1:0] delta_i,
  output logic [N-1:0] sum_o
);
`ifdef FMAP_ACC_SAT_EN
  // One guard bit. Overflow occurs when the guard bit and the sign bit differ.
  logic [N:0] full;
  assign full = {opnd_i[N-1], opnd_i} + {{(N+1-W){delta_i[W-1]}}, delta_i};
  always_comb begin
    sum_o = full[N-1:0];
    if (full[N] != full[N-1])
      sum_o = full[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
`else
  assign sum_o = opnd_i + {{(N-W){delta_i[W-1]}}, delta_i};
`endif
endmodule

module fmap_accumulator #(
  parameter int BITS_PER_COORDINATE = 8,
  parameter int OUT_CHANNELS        = 4,
  parameter int BITS_PER_NEURON     = 12,
  parameter int BITS_PER_WEIGHT     = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    ev_valid,
  output logic                                    ev_ready,
  input  logic [BITS_PER_COORDINATE-1:0]          ev_x,
  input  logic [BITS_PER_COORDINATE-1:0]          ev_y,
  input  logic [OUT_CHANNELS*BITS_PER_WEIGHT-1:0] ev_delta,
  output logic                                    read_req,
  output logic [2*BITS_PER_COORDINATE-1:0]        coord_get,
  input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] rd_data,
  output logic                                    write_req,
  output logic [2*BITS_PER_COORDINATE-1:0]        coord_wtr,
  output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] wr_data,
  output logic                                    busy
);
  localparam int CW = 2 * BITS_PER_COORDINATE;

  typedef logic [OUT_CHANNELS-1:0][BITS_PER_NEURON-1:0] vec_t;
  typedef struct packed {
    logic [CW-1:0] coord;
    vec_t          data;
  } stg_t;

  // vld_pipe_q[1]=S2, [2]=S3, [3]=S4
  logic [3:1] vld_pipe_q;
  logic [CW-1:0] s2_coord_q;
  logic [OUT_CHANNELS-1:0][BITS_PER_WEIGHT-1:0] s2_delta_q;
  stg_t s3_q, s3_d, s4_q;
  vec_t rd_vec, opnd, sum;
  logic accept;

  // Masking with rst keeps the read port quiet while reset is held.
  assign ev_ready  = en;
  assign accept    = ev_valid & en & ~rst;
  assign read_req  = accept;
  assign coord_get = accept ? {ev_x, ev_y} : '0;

  assign rd_vec = rd_data;

  // The newest in-flight value wins. An S4 hit covers the case where a read
  // issued in the same cycle as the S3 write returned stale data.
  always_comb begin
    opnd = rd_vec;
    if (vld_pipe_q[2] && (s3_q.coord == s2_coord_q))
      opnd = s3_q.data;
    else if (vld_pipe_q[3] && (s4_q.coord == s2_coord_q))
      opnd = s4_q.data;
  end

  for (genvar g = 0; g < OUT_CHANNELS; g++) begin : g_lane
    fmap_acc_lane #(.N(BITS_PER_NEURON), .W(BITS_PER_WEIGHT)) u_lane (
      .opnd_i (opnd[g]),
      .delta_i(s2_delta_q[g]),
      .sum_o  (sum[g])
    );
  end

  always_comb begin
    s3_d.coord = s2_coord_q;
    s3_d.data  = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s2_coord_q <= '0;
      s2_delta_q <= '0;
      s3_q       <= '0;
      s4_q       <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[2:1], accept};
      if (accept) begin
        s2_coord_q <= {ev_x, ev_y};
        s2_delta_q <= ev_delta;
      end
      if (vld_pipe_q[1]) s3_q <= s3_d;
      if (vld_pipe_q[2]) s4_q <= s3_q;
    end
  end

  assign write_req = vld_pipe_q[2];
  assign coord_wtr = s3_q.coord;
  assign wr_data   = s3_q.data;
  assign busy      = |vld_pipe_q;
endmodule

// File: doc/fmap_accumulator.md
Name: fmap_accumulator

Overview:
- Read-modify-write initiator on the convolution-side feature-map ports, i.e. the requester that drives the arbiter's conv read/write ports.
- Accepts a stream of (coordinate, per-channel delta) events and reads the stored neuron vector.
- Adds the deltas to every channel and writes the result back.
- Pipelined at one event per cycle, with forwarding so back-to-back events to the same coordinate accumulate correctly.

Parameters:
- BITS_PER_COORDINATE, 8, width of each of x and y.
- OUT_CHANNELS, 4, number of feature-map channels per coordinate.
- BITS_PER_NEURON, 12, signed width of each stored neuron value.
- BITS_PER_WEIGHT, 6, signed width of each delta value; must be ≤ BITS_PER_NEURON.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  accept enable; high only while the arbiter is in CONVOLUTION mode.
- ev_valid  in  1  event valid.
- ev_ready  out  1  event accepted when ev_valid && ev_ready.
- ev_x, ev_y  in  BITS_PER_COORDINATE each  event coordinate.
- ev_delta  in  OUT_CHANNELS*BITS_PER_WEIGHT  packed signed deltas; channel i at [i*BITS_PER_WEIGHT +: BITS_PER_WEIGHT].
- read_req  out  1  read request to the arbiter read port.
- coord_get  out  2*BITS_PER_COORDINATE  read coordinate {x,y}.
- rd_data  in  OUT_CHANNELS*BITS_PER_NEURON  packed read data; channel i at [i*BITS_PER_NEURON +: BITS_PER_NEURON].
- write_req  out  1  write request to the arbiter write port.
- coord_wtr  out  2*BITS_PER_COORDINATE  write coordinate {x,y}.
- wr_data  out  OUT_CHANNELS*BITS_PER_NEURON  packed write data, same channel layout as rd_data.
- busy  out  1  high while any pipeline stage is valid.

Behaviour:
- Reset values: read_req=0, coord_get=0, write_req=0, coord_wtr=0, wr_data=0, busy=0. All stage-valid bits and forwarding registers are cleared.
- ev_ready = en, combinational. There is no backpressure from memory: the arbiter always grants.
- S1 (cycle t, on handshake): read_req=1 and coord_get={ev_x,ev_y}, both combinational from the event. Event coordinate and deltas are registered into S2.
- Memory contract: rd_data is valid in cycle t+1 for a read issued in cycle t. A read and a write to the same address in the same cycle return the old data.
- S2 (t+1): operand is selected, then sum[i] = operand[i] + sign_extend(delta[i]). The sum is registered into S3.
- Operand priority in S2:
  - S3 value if S3 is valid and its coordinate equals the S2 coordinate;
  - else S4 value if S4 is valid and its coordinate matches;
  - else rd_data.
- S3 (t+2): write_req=1; coord_wtr and wr_data come from registers. S3 contents are copied into S4 (t+3), which exists only for forwarding.
- Latency: event handshake to write_req is 2 cycles. Throughput is 1 event per cycle.
- Arithmetic: each channel is independent, signed two's complement, BITS_PER_NEURON wide, using the overflow rule from the Optional Feature.
- Address mapping is the arbiter's job; this block handles coordinates only.
- busy = S2 or S3 or S4 valid. A controller switches mode only after en=0 and busy=0.
- en falls mid-stream: no new accepts; events already in flight complete and write normally.
- rst mid-operation: all stages are invalidated on that edge. write_req is 0 in the following cycle and pending writes are discarded.
- x and y compare as a single 2*BITS_PER_COORDINATE word. There is no coordinate bounds check.

Optional Feature:
- Macro FMAP_ACC_SAT_EN.
- Defined: each channel sum saturates to [-2^(BITS_PER_NEURON-1), 2^(BITS_PER_NEURON-1)-1].
- Undefined: the sum wraps modulo 2^BITS_PER_NEURON, and the saturation logic is absent.

Test Plan:
- Single event: (3,5) with deltas {+1,-2,+3,0}, memory initially {10,10,10,10} → read_req in cycle 0; write_req in cycle 2 at (3,5) with data {11,8,13,10}.
- Back-to-back same coordinate: 3 consecutive events to (0,0), each delta +1, memory 0 → writes of 1, 2, 3 in cycles 2, 3, 4; final memory 3. Exercises S3 and S4 forwarding.
- Event gap: events to (7,7) in cycle 0 and cycle 2, each +5, memory 0 → second write is 10, forwarded from S4.
- Overflow: value 2047 (BITS_PER_NEURON=12) plus delta +5 → with FMAP_ACC_SAT_EN, 2047; without, -2044.
- Reset mid-stream: rst asserted in the cycle after an accept → write_req stays 0 and busy=0 in the next cycle.
- en drop: en=0 while 2 events are in flight → ev_ready=0, both writes still occur, then busy falls.
